// File: rtl/serial_chunk_adder.sv
// Wide adder that consumes one BIT_WIDTH chunk per clock through a small carry
// look-ahead block, with valid/ready handshakes on operand and result sides.

module carry_look_ahead_exponential #(
  parameter int BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BIT_WIDTH:0]   carry_out,
  output logic [BIT_WIDTH-1:0] and_result
);
  logic [BIT_WIDTH-1:0] g, p;
  logic                 t, c;

  assign g          = a & b;
  assign p          = a ^ b;
  assign and_result = g;

  // Every carry is a flat sum of products over all lower generate/propagate
  // terms, so depth stays constant while term count grows with the bit index.
  always_comb begin
    carry_out    = '0;
    carry_out[0] = carry_in;
    t            = 1'b0;
    c            = 1'b0;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      t = carry_in;
      for (int k = 0; k <= i; k++) t = t & p[k];
      c = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int k = j + 1; k <= i; k++) t = t & p[k];
        c = c | t;
      end
      carry_out[i+1] = c;
    end
  end
endmodule

module serial_chunk_adder #(
  parameter int BIT_WIDTH = 4,
  parameter int CHUNKS    = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BIT_WIDTH*CHUNKS-1:0] operand1,
  input  logic [BIT_WIDTH*CHUNKS-1:0] operand2,
  input  logic                        carry_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BIT_WIDTH*CHUNKS-1:0] sum,
  output logic                        carry_out,
  output logic                        overflow
);
  localparam int TW = BIT_WIDTH * CHUNKS;
  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        op_a, op_b, res;
  logic                 carry_q, ovf_q;
  logic [CW-1:0]        cnt;
  logic [BIT_WIDTH:0]   cla_c;
  logic [BIT_WIDTH-1:0] chunk;
  logic                 last;

  carry_look_ahead_exponential #(.BIT_WIDTH(BIT_WIDTH)) u_cla (
    .a         (op_a[BIT_WIDTH-1:0]),
    .b         (op_b[BIT_WIDTH-1:0]),
    .carry_in  (carry_q),
    .carry_out (cla_c),
    .and_result()
  );

  assign chunk = op_a[BIT_WIDTH-1:0] ^ op_b[BIT_WIDTH-1:0] ^ cla_c[BIT_WIDTH-1:0];
  assign last  = (cnt == CW'(CHUNKS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a    <= '0;
      op_b    <= '0;
      res     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_a    <= operand1;
          op_b    <= operand2;
          carry_q <= carry_in;
          cnt     <= '0;
        end
        RUN: begin
          op_a    <= op_a >> BIT_WIDTH;
          op_b    <= op_b >> BIT_WIDTH;
          // New chunk enters at the top; after CHUNKS shifts chunk 0 sits at bit 0.
          res     <= (res >> BIT_WIDTH) | (TW'(chunk) << (TW - BIT_WIDTH));
          carry_q <= cla_c[BIT_WIDTH];
          if (last) ovf_q <= cla_c[BIT_WIDTH-1] ^ cla_c[BIT_WIDTH];
          else      cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = res;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed and randomized checks of serial_chunk_adder against an arithmetic model.

module tb_serial_chunk_adder;
  localparam int TW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, carry_in, out_valid, out_ready, carry_out, overflow;
  logic [TW-1:0] operand1, operand2, sum;

  logic       d_in_valid, d_in_ready, d_carry_in, d_out_valid, d_out_ready, d_carry_out, d_overflow;
  logic [7:0] d_operand1, d_operand2, d_sum;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  serial_chunk_adder #(.BIT_WIDTH(4), .CHUNKS(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operand1(operand1), .operand2(operand2), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(carry_out), .overflow(overflow)
  );

  serial_chunk_adder #(.BIT_WIDTH(8), .CHUNKS(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .operand1(d_operand1), .operand2(d_operand2), .carry_in(d_carry_in),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .sum(d_sum),
    .carry_out(d_carry_out), .overflow(d_overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Signed overflow from the integer range rather than from carries.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic c,
                       output logic [15:0] s, output logic co, output logic ov);
    logic [16:0] full;
    int          si;
    full = {1'b0, a} + {1'b0, b} + {16'd0, c};
    s    = full[15:0];
    co   = full[16];
    si   = int'($signed(a)) + int'($signed(b)) + int'(c);
    ov   = (si > 32767) || (si < -32768);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic acc;
    acc      = 1'b0;
    operand1 = a;
    operand2 = b;
    carry_in = c;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    check("accept", acc, 1'b1);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [15:0] es, input logic ec, input logic eo);
    int cyc;
    out_ready = 1'b1;
    send(a, b, c);
    wait_valid(cyc);
    check({tag, "_latency"}, cyc, 4);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, carry_out, ec);
    check({tag, "_ovf"}, overflow, eo);
    step();
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    int          cyc, got;
    logic        hs;
    logic [15:0] a, b, es;
    logic        c, ec, eo;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    operand1 = '0; operand2 = '0; carry_in = 1'b0;
    d_in_valid = 1'b0; d_out_ready = 1'b1; d_operand1 = '0; d_operand2 = '0; d_carry_in = 1'b0;
    step(); step();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 16'h0);
    check("rst_cout", carry_out, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_d_in_ready", d_in_ready, 1'b1);
    reset = 1'b0;
    step();

    directed("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Backpressure: result must hold while a stray in_valid is ignored.
    out_ready = 1'b0;
    send(16'h1234, 16'h4321, 1'b1);
    wait_valid(cyc);
    check("bp_latency", cyc, 4);
    for (int i = 0; i < 10; i++) begin
      check("bp_sum_hold", sum, 16'h5556);
      check("bp_valid_hold", out_valid, 1'b1);
      check("bp_cout_hold", carry_out, 1'b0);
      in_valid = (i == 3);
      operand1 = 16'hAAAA;
      operand2 = 16'h5555;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_valid_drop", out_valid, 1'b0);
    check("bp_ready_back", in_ready, 1'b1);
    step();
    check("bp_no_dup", out_valid, 1'b0);
    check("bp_still_idle", in_ready, 1'b1);

    // Asynchronous reset two cycles into RUN.
    send(16'h1234, 16'h4321, 1'b0);
    step(); step();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_sum", sum, 16'h0);
    step();
    reset = 1'b0;
    step();
    directed("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Single-chunk instance.
    d_operand1 = 8'hFF; d_operand2 = 8'h01; d_carry_in = 1'b1;
    check("deg_ready", d_in_ready, 1'b1);
    d_in_valid = 1'b1;
    step();
    d_in_valid = 1'b0;
    cyc = 0;
    while (d_out_valid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    check("deg_latency", cyc, 1);
    check("deg_sum", d_sum, 8'h01);
    check("deg_cout", d_carry_out, 1'b1);
    check("deg_ovf", d_overflow, 1'b0);
    step();
    check("deg_valid_drop", d_out_valid, 1'b0);

    // Random stream with random downstream backpressure.
    got = 0;
    for (int n = 0; n < 1000; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom_range(0, 1));
      model(a, b, c, es, ec, eo);
      send(a, b, c);
      hs = 1'b0;
      for (int k = 0; k < 100 && !hs; k++) begin
        out_ready = 1'($urandom_range(0, 1));
        hs = (out_valid === 1'b1) && out_ready;
        if (hs) begin
          check("rnd_sum", sum, es);
          check("rnd_cout", carry_out, ec);
          check("rnd_ovf", overflow, eo);
          got++;
        end
        step();
      end
      check("rnd_handshake", hs, 1'b1);
      check("rnd_no_dup", out_valid, 1'b0);
    end
    check("rnd_count", got, 1000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/serial_chunk_adder.md
# serial_chunk_adder

Multi-cycle wide adder that sums two `BIT_WIDTH*CHUNKS`-bit operands one `BIT_WIDTH`-bit chunk per clock. It is the consumer stage of `carry_look_ahead_exponential`: one instance of that block resolves the carries for the current chunk, and a registered carry links successive chunks. A valid/ready handshake sits on each side, so the block drops into operand/result pipelines in the datapath.

## Interface

- `BIT_WIDTH`, default 4: chunk width; the width passed to the internal `carry_look_ahead_exponential` instance.
- `CHUNKS`, default 4: number of chunks. Total width `TW = BIT_WIDTH*CHUNKS`. Legal range is `CHUNKS >= 1`.

- `clock`  in  1: single clock. All state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operand set presented.
- `in_ready`  out  1: block can accept an operand set.
- `operand1`  in  TW: first addend.
- `operand2`  in  TW: second addend.
- `carry_in`  in  1: carry into bit 0.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: downstream accepts the result.
- `sum`  out  TW: `(operand1 + operand2 + carry_in) mod 2^TW`.
- `carry_out`  out  1: carry out of bit `TW-1`.
- `overflow`  out  1: two's-complement overflow, computed as carry into bit `TW-1` XOR carry out of bit `TW-1`.

## Operation

- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`, capture `operand1`, `operand2` and `carry_in` into internal shift registers.
  - Clear the chunk counter to 0 and go to RUN.
- **RUN**, one chunk per cycle, for `k` = 0 .. `CHUNKS-1`:
  - The CLA instance gets the low `BIT_WIDTH` bits of both operand shift registers and the carry register.
  - Sum chunk = `a ^ b ^ carry_out[BIT_WIDTH-1:0]`. It is shifted into the top of the result register, which shifts right by `BIT_WIDTH`.
  - The carry register loads `carry_out[BIT_WIDTH]`.
  - The operand registers shift right by `BIT_WIDTH`.
  - On the last chunk (`k == CHUNKS-1`):
    - the `overflow` register loads `carry_out[BIT_WIDTH-1] ^ carry_out[BIT_WIDTH]`;
    - the state goes to DONE.
  - The `and_result` output of the CLA instance is unused.
- **DONE**
  - `out_valid` = 1.
  - `sum`, `carry_out` and `overflow` are held stable until `out_valid && out_ready`, then the state returns to IDLE.
- `in_valid` is ignored outside IDLE. Nothing is captured and no error is flagged.
- The counter width is `max(1, $clog2(CHUNKS))`. The counter never wraps past `CHUNKS-1`.
- When `CHUNKS = 1`, RUN lasts exactly one cycle.
- Reset (any state, including mid-RUN or DONE):
  - state goes to IDLE;
  - `in_ready`=1, `out_valid`=0;
  - `sum`=0, `carry_out`=0, `overflow`=0;
  - counter, carry, operand and result registers are cleared;
  - the in-flight operation is discarded.
- No input is captured while `reset` is high.

## Timing

- `in_ready` and `out_valid` are registered state decodes. There is no combinational path from `in_valid` or `out_ready` to any output.
- Accept edge is T0. RUN occupies edges T1..T`CHUNKS`. `out_valid` rises after edge T`CHUNKS`.
- Latency from acceptance to `out_valid` is `CHUNKS` cycles.
- With `out_ready` held high, `in_ready` rises one cycle after the output handshake. Minimum initiation interval is `CHUNKS+2` cycles.
- While `out_valid`=1 and `out_ready`=0, all outputs hold for any number of cycles.
- `sum`, `carry_out` and `overflow` are only meaningful while `out_valid`=1. During RUN they are undefined but deterministic.
- Critical path: one `BIT_WIDTH`-bit CLA plus the XOR into the result register.

## Test plan

- **Carry ripple across chunks** (`BIT_WIDTH`=4, `CHUNKS`=4): accept `0xFFFF` + `0x0001`, `carry_in`=0, `out_ready`=1 → `out_valid` exactly 4 cycles after accept; `sum`=`0x0000`, `carry_out`=1, `overflow`=0.
- **Signed overflow**: `0x7FFF` + `0x0001`, `carry_in`=0 → `sum`=`0x8000`, `carry_out`=0, `overflow`=1. Also `0x8000` + `0x8000` → `sum`=`0x0000`, `carry_out`=1, `overflow`=1.
- **Carry-in with backpressure**: `0x1234` + `0x4321`, `carry_in`=1, `out_ready`=0 for 10 cycles → `sum`=`0x5556` held stable every cycle. An `in_valid` pulse with other operands during this time is ignored. Raising `out_ready` gives one handshake, then `in_ready`=1 the next cycle.
- **Reset mid-operation**: assert `reset` asynchronously 2 cycles into RUN → outputs immediately show `out_valid`=0, `in_ready`=1, `sum`=0. After release, `0x00FF` + `0x0001` yields `0x0100`, unaffected by the aborted operation.
- **Degenerate width** (`CHUNKS`=1, `BIT_WIDTH`=8): `0xFF` + `0x01`, `carry_in`=1 → `sum`=`0x01`, `carry_out`=1, `overflow`=0, latency 1 cycle.
- **Randomized back-to-back stream**: 1000 operand sets with `out_ready` toggling randomly → every result matches the reference sum, and none are lost or duplicated.
